// File: rtl/mux4_pkg.sv
// Shared definitions for the 4-channel stream mux/demux pair.
package mux4_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter4
  import mux4_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output logic [NUM_CH-1:0] gnt,
  output sel_t              gnt_idx
);

  sel_t cand;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    cand    = ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = sel_t'(ptr + sel_t'(k));
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt_idx   = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux4.sv
// 4:1 round-robin stream merger with one registered output stage; beats tagged with source index.
module rr_stream_mux4
  import mux4_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output sel_t                     out_sel
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  sel_t              sel_q, sel_d;
  sel_t              ptr_q, ptr_d;

  logic [NUM_CH-1:0] gnt;
  sel_t              gnt_idx;
  logic              can_load;
  logic              any_req;
  logic              load;
  logic [DATA_W-1:0] gnt_data;

  rr_arbiter4 u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign can_load = !valid_q || out_ready;
  assign any_req  = |in_valid;
  assign load     = can_load && any_req;
  assign gnt_data = in_data[int'(gnt_idx)*DATA_W +: DATA_W];

  // Gated by rst_n so no source sees a handshake while reset is held.
  assign in_ready = gnt & {NUM_CH{load && rst_n}};

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = gnt_data;
      sel_d   = gnt_idx;
      ptr_d   = sel_t'(gnt_idx + sel_t'(1));
    end else if (can_load) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule
